screen_mode_ctrl: RTL and testbench

Parametrised successor to the menu/game background renderer. It tracks the top-level screen mode (menu, game, victory, game over, multiplayer wait) and renders the matching background into the pixel pipeline. It supports a configurable set of clickable buttons, hover highlighting, edge-detected clicks and a frame-counted multiplayer-wait timeout. It sits in the VGA chain between the timing generator and the sprite/overlay stages, and feeds mode flags to the game logic and mouse renderer.

---
 rtl/screen_mode_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_screen_mode_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_mode_ctrl.sv
// Top-level screen mode tracker and background renderer for the VGA chain.
// Handles clickable menu buttons, hover highlight and the multiplayer-wait timeout.
module screen_mode_ctrl #(
    parameter int                      BTN_COUNT           = 2,
    parameter logic [12*BTN_COUNT-1:0] BTN_X               = {12'd432, 12'd432},
    parameter logic [12*BTN_COUNT-1:0] BTN_Y               = {12'd540, 12'd400},
    parameter int                      BTN_W               = 128,
    parameter int                      BTN_H               = 80,
    parameter int                      TOP_V_LINE          = 317,
    parameter int                      BOTTOM_V_LINE       = 617,
    parameter int                      LEFT_H_LINE         = 361,
    parameter int                      RIGHT_H_LINE        = 661,
    parameter int                      BORDER              = 10,
    parameter logic [11:0]             MENU_RGB            = 12'h000,
    parameter logic [11:0]             VICTORY_RGB         = 12'h2f2,
    parameter logic [11:0]             OVER_RGB            = 12'hf22,
    parameter logic [11:0]             WAIT_RGB            = 12'h22f,
    parameter logic [11:0]             BTN_RGB             = 12'hfff,
    parameter logic [11:0]             BTN_HOVER_RGB       = 12'h0f0,
    parameter int                      WAIT_TIMEOUT_FRAMES = 600
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic [11:0]          hcount_in,
    input  logic [11:0]          vcount_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 hblnk_in,
    input  logic                 vblnk_in,
    input  logic [11:0]          xpos,
    input  logic [11:0]          ypos,
    input  logic                 mouse_left,
    input  logic                 game_on,
    input  logic                 menu_on,
    input  logic                 game_over,
    input  logic                 victory,
    input  logic                 opponent_ready,
    output logic [11:0]          hcount_out,
    output logic [11:0]          vcount_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 hblnk_out,
    output logic                 vblnk_out,
    output logic [11:0]          rgb_out,
    output logic [2:0]           mode,
    output logic                 multiplayer,
    output logic                 player_ready,
    output logic                 display_buttons,
    output logic [BTN_COUNT-1:0] btn_hover,
    output logic [BTN_COUNT-1:0] btn_click
);

    typedef enum logic [2:0] {
        MENU       = 3'd0,
        GAME       = 3'd1,
        VICTORY    = 3'd2,
        GAME_OVER  = 3'd3,
        MULTI_WAIT = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic                  multi_sel_reg, multi_sel_next;
    logic                  mouse_prev_reg, click_armed_reg;
    logic [15:0]           frame_cnt_reg, frame_cnt_next;
    logic [BTN_COUNT-1:0]  mouse_hit, pix_hit, mouse_sel, pix_sel;
    logic                  click_edge, click_btn0, click_btn1, click_none;
    logic                  vsync_rise, timeout;
    logic                  in_frame;
    logic [11:0]           rgb_next;

    genvar gi;
    generate
        for (gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
            localparam int X0 = int'(BTN_X[12*gi +: 12]);
            localparam int Y0 = int'(BTN_Y[12*gi +: 12]);
            assign mouse_hit[gi] = (int'(xpos) >= X0) && (int'(xpos) <= X0 + BTN_W - 1) &&
                                   (int'(ypos) >= Y0) && (int'(ypos) <= Y0 + BTN_H - 1);
            assign pix_hit[gi]   = (int'(hcount_in) >= X0) && (int'(hcount_in) <= X0 + BTN_W - 1) &&
                                   (int'(vcount_in) >= Y0) && (int'(vcount_in) <= Y0 + BTN_H - 1);
        end
    endgenerate

    // Overlapping buttons resolve to the lowest index.
    function automatic logic [BTN_COUNT-1:0] first_hit(input logic [BTN_COUNT-1:0] h);
        logic [BTN_COUNT-1:0] r;
        logic                 found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < BTN_COUNT; i++) begin
            if (h[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign mouse_sel = first_hit(mouse_hit);
    assign pix_sel   = first_hit(pix_hit);

    // Arming blocks a press held through reset from registering as a click.
    assign click_edge = mouse_left && !mouse_prev_reg && click_armed_reg;
    assign click_btn0 = click_edge && mouse_sel[0];
    assign click_btn1 = click_edge && mouse_sel[1];
    assign click_none = click_edge && (mouse_sel == '0);

    assign vsync_rise     = vsync_in && !vsync_out;
    assign frame_cnt_next = frame_cnt_reg + 16'((vsync_rise && frame_cnt_reg != 16'hffff) ? 1 : 0);
    assign timeout        = (WAIT_TIMEOUT_FRAMES != 0) && (frame_cnt_next >= 16'(WAIT_TIMEOUT_FRAMES));

    always_comb begin
        state_next     = state_reg;
        multi_sel_next = multi_sel_reg;
        case (state_reg)
            MENU: begin
                if (game_on)         begin state_next = GAME; multi_sel_next = 1'b0; end
                else if (click_btn0) begin state_next = GAME; multi_sel_next = 1'b0; end
                else if (click_btn1) begin state_next = MULTI_WAIT; multi_sel_next = 1'b1; end
                else if (game_over)  state_next = GAME_OVER;
                else if (victory)    state_next = VICTORY;
            end
            GAME: begin
                if (menu_on)        state_next = MENU;
                else if (game_over) state_next = GAME_OVER;
                else if (victory)   state_next = VICTORY;
            end
            VICTORY, GAME_OVER: begin
                if (game_on)         state_next = GAME;
                else if (menu_on)    state_next = MENU;
                else if (click_btn0) begin state_next = GAME; multi_sel_next = 1'b0; end
                else if (click_btn1) begin state_next = MULTI_WAIT; multi_sel_next = 1'b1; end
                else if (click_none) state_next = MENU;
            end
            MULTI_WAIT: begin
                if (click_edge)          state_next = MENU;
                else if (opponent_ready) state_next = GAME;
                else if (timeout)        state_next = MENU;
            end
            default: state_next = MENU;
        endcase
        if (state_next == MENU) multi_sel_next = 1'b0;
    end

    assign in_frame = (int'(hcount_in) >= LEFT_H_LINE - BORDER) && (int'(hcount_in) < RIGHT_H_LINE + BORDER) &&
                      (int'(vcount_in) >= TOP_V_LINE - BORDER) && (int'(vcount_in) < BOTTOM_V_LINE + BORDER) &&
                      !((int'(hcount_in) >= LEFT_H_LINE) && (int'(hcount_in) < RIGHT_H_LINE) &&
                        (int'(vcount_in) >= TOP_V_LINE) && (int'(vcount_in) < BOTTOM_V_LINE));

    // Colour is based on the state already registered when this pixel arrives.
    always_comb begin
        rgb_next = MENU_RGB;
        if (hblnk_in || vblnk_in)        rgb_next = 12'h000;
        else if (vcount_in == 12'd0)     rgb_next = 12'hff0;
        else if (vcount_in == 12'd767)   rgb_next = 12'hf00;
        else if (hcount_in == 12'd0)     rgb_next = 12'h0f0;
        else if (hcount_in == 12'd1023)  rgb_next = 12'h00f;
        else if (state_reg == GAME && in_frame) rgb_next = 12'hfff;
        else if (display_buttons && pix_sel != '0)
            rgb_next = ((pix_sel & btn_hover) != '0) ? BTN_HOVER_RGB : BTN_RGB;
        else begin
            case (state_reg)
                VICTORY:    rgb_next = VICTORY_RGB;
                GAME_OVER:  rgb_next = OVER_RGB;
                MULTI_WAIT: rgb_next = WAIT_RGB;
                GAME:       rgb_next = 12'h000;
                default:    rgb_next = MENU_RGB;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg       <= MENU;
            multi_sel_reg   <= 1'b0;
            mouse_prev_reg  <= 1'b0;
            click_armed_reg <= 1'b0;
            frame_cnt_reg   <= '0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            hsync_out       <= 1'b0;
            vsync_out       <= 1'b0;
            hblnk_out       <= 1'b0;
            vblnk_out       <= 1'b0;
            rgb_out         <= '0;
            multiplayer     <= 1'b0;
            player_ready    <= 1'b0;
            display_buttons <= 1'b1;
            btn_hover       <= '0;
            btn_click       <= '0;
        end else begin
            state_reg      <= state_next;
            multi_sel_reg  <= multi_sel_next;
            mouse_prev_reg <= mouse_left;
            if (!mouse_left) click_armed_reg <= 1'b1;
            frame_cnt_reg  <= (state_reg == MULTI_WAIT) ? frame_cnt_next : 16'd0;
            hcount_out     <= hcount_in;
            vcount_out     <= vcount_in;
            hsync_out      <= hsync_in;
            vsync_out      <= vsync_in;
            hblnk_out      <= hblnk_in;
            vblnk_out      <= vblnk_in;
            rgb_out        <= rgb_next;
            multiplayer    <= (state_next == MULTI_WAIT) || (state_next == GAME && multi_sel_next);
            player_ready   <= (state_next == MULTI_WAIT);
            display_buttons <= (state_next == MENU) || (state_next == VICTORY) || (state_next == GAME_OVER);
            btn_hover      <= mouse_sel;
            btn_click      <= {BTN_COUNT{click_edge && display_buttons}} & mouse_sel;
        end
    end

    assign mode = state_reg;

endmodule

// File: tb/tb_screen_mode_ctrl.sv
// Scoreboard bench for screen_mode_ctrl: expectations are queued with each
// stimulus step and compared against the outputs after the next clock edge.
module tb_screen_mode_ctrl;

    localparam int F_MODE  = 0;
    localparam int F_RGB   = 1;
    localparam int F_CLICK = 2;
    localparam int F_MP    = 3;
    localparam int F_PR    = 4;
    localparam int F_DISP  = 5;
    localparam int F_HOVER = 6;
    localparam int F_HCNT  = 7;
    localparam int F_HS    = 8;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] hcount_in, vcount_in, xpos, ypos;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in, mouse_left;
    logic        game_on, menu_on, game_over, victory, opponent_ready;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [2:0]  mode;
    logic        multiplayer, player_ready, display_buttons;
    logic [1:0]  btn_hover, btn_click;

    typedef struct {
        string       tag;
        int          field;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    screen_mode_ctrl #(.WAIT_TIMEOUT_FRAMES(3)) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .xpos(xpos), .ypos(ypos), .mouse_left(mouse_left),
        .game_on(game_on), .menu_on(menu_on), .game_over(game_over), .victory(victory),
        .opponent_ready(opponent_ready),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .mode(mode),
        .multiplayer(multiplayer), .player_ready(player_ready), .display_buttons(display_buttons),
        .btn_hover(btn_hover), .btn_click(btn_click)
    );

    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end else begin
            $display("ok   %s act=%0h", tag, act);
        end
    endtask

    function automatic logic [31:0] dut_field(input int f);
        case (f)
            F_MODE:  return 32'(mode);
            F_RGB:   return 32'(rgb_out);
            F_CLICK: return 32'(btn_click);
            F_MP:    return 32'(multiplayer);
            F_PR:    return 32'(player_ready);
            F_DISP:  return 32'(display_buttons);
            F_HOVER: return 32'(btn_hover);
            F_HCNT:  return 32'(hcount_out);
            F_HS:    return 32'(hsync_out);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int f, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.field = f;
        e.exp   = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge pclk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, dut_field(e.field), e.exp);
        end
    endtask

    task automatic pixel(input int h, input int v, input logic [11:0] rgb, input string tag);
        hcount_in = 12'(h);
        vcount_in = 12'(v);
        expect_out(tag, F_RGB, 32'(rgb));
        expect_out({tag, "_hcnt"}, F_HCNT, 32'(h));
        tick();
    endtask

    int          nclicks;
    logic [1:0]  click_seen;

    initial begin
        rst = 1'b1;
        hcount_in = '0; vcount_in = 12'd100;
        hsync_in = 1'b1; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
        xpos = 12'd440; ypos = 12'd410; mouse_left = 1'b1;
        game_on = 0; menu_on = 0; game_over = 0; victory = 0; opponent_ready = 0;
        tick();
        expect_out("rst_mode", F_MODE, 0);
        expect_out("rst_disp", F_DISP, 1);
        expect_out("rst_rgb", F_RGB, 0);
        expect_out("rst_click", F_CLICK, 0);
        expect_out("rst_mp", F_MP, 0);
        expect_out("rst_pr", F_PR, 0);
        expect_out("rst_hsync", F_HS, 0);
        tick();

        // Press held through reset must not click.
        rst = 1'b0;
        hsync_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out("held_mode", F_MODE, 0);
            expect_out("held_click", F_CLICK, 0);
            tick();
        end
        mouse_left = 1'b0;
        tick();
        mouse_left = 1'b1;
        expect_out("play_click", F_CLICK, 1);
        expect_out("play_mode", F_MODE, 1);
        expect_out("play_mp", F_MP, 0);
        expect_out("play_disp", F_DISP, 0);
        tick();
        expect_out("play_click_once", F_CLICK, 0);
        expect_out("play_mode_hold", F_MODE, 1);
        tick();
        mouse_left = 1'b0;

        menu_on = 1'b1;
        expect_out("menu_mode", F_MODE, 0);
        expect_out("menu_disp", F_DISP, 1);
        tick();
        menu_on = 1'b0;

        // Long hold over the multiplayer button.
        ypos = 12'd560;
        tick();
        mouse_left = 1'b1;
        nclicks = 0;
        click_seen = '0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (btn_click != 2'b00) begin
                nclicks++;
                click_seen = btn_click;
            end
        end
        check_val("hold_nclicks", 32'(nclicks), 1);
        check_val("hold_click_btn", 32'(click_seen), 2);
        expect_out("wait_mode", F_MODE, 4);
        expect_out("wait_pr", F_PR, 1);
        expect_out("wait_mp", F_MP, 1);
        tick();
        mouse_left = 1'b0;
        opponent_ready = 1'b1;
        expect_out("opp_mode", F_MODE, 1);
        expect_out("opp_mp", F_MP, 1);
        expect_out("opp_pr", F_PR, 0);
        tick();
        opponent_ready = 1'b0;

        // Timeout after three frames.
        menu_on = 1'b1;
        expect_out("menu2_mode", F_MODE, 0);
        expect_out("menu2_mp", F_MP, 0);
        tick();
        menu_on = 1'b0;
        mouse_left = 1'b1;
        expect_out("wait2_mode", F_MODE, 4);
        expect_out("wait2_click", F_CLICK, 2);
        tick();
        mouse_left = 1'b0;
        tick();
        for (int k = 1; k <= 3; k++) begin
            vsync_in = 1'b1;
            expect_out($sformatf("vs%0d_mode", k), F_MODE, (k == 3) ? 0 : 4);
            if (k == 3) expect_out("to_mp", F_MP, 0);
            tick();
            vsync_in = 1'b0;
            tick();
        end

        // Simultaneous game_over and victory, then click on empty space.
        game_on = 1'b1;
        expect_out("game_mode", F_MODE, 1);
        tick();
        game_on = 1'b0;
        game_over = 1'b1;
        victory = 1'b1;
        expect_out("over_mode", F_MODE, 3);
        tick();
        game_over = 1'b0;
        victory = 1'b0;
        xpos = 12'd10; ypos = 12'd10;
        mouse_left = 1'b1;
        expect_out("empty_mode", F_MODE, 0);
        expect_out("empty_click", F_CLICK, 0);
        tick();
        mouse_left = 1'b0;

        // Menu pixels.
        xpos = 12'd440; ypos = 12'd410;
        tick();
        expect_out("hover_btn0", F_HOVER, 1);
        pixel(450, 420, 12'h0f0, "px_hover");
        pixel(450, 550, 12'hfff, "px_btn1");
        pixel(500, 0, 12'hff0, "px_row0");
        pixel(500, 767, 12'hf00, "px_row767");
        pixel(0, 300, 12'h0f0, "px_col0");
        pixel(1023, 300, 12'h00f, "px_col1023");
        hblnk_in = 1'b1;
        pixel(450, 420, 12'h000, "px_hblnk");
        hblnk_in = 1'b0;
        xpos = 12'd900; ypos = 12'd900;
        tick();
        expect_out("hover_none", F_HOVER, 0);
        pixel(450, 420, 12'hfff, "px_idle");

        // Game pixels.
        game_on = 1'b1;
        expect_out("game2_mode", F_MODE, 1);
        tick();
        game_on = 1'b0;
        pixel(355, 400, 12'hfff, "px_frame_l");
        pixel(500, 400, 12'h000, "px_arena");
        pixel(665, 400, 12'hfff, "px_frame_r");

        victory = 1'b1;
        expect_out("vic_mode", F_MODE, 2);
        expect_out("vic_disp", F_DISP, 1);
        tick();
        victory = 1'b0;
        pixel(100, 100, 12'h2f2, "px_victory");
        xpos = 12'd440; ypos = 12'd410;
        mouse_left = 1'b1;
        expect_out("vic_play_mode", F_MODE, 1);
        expect_out("vic_play_click", F_CLICK, 1);
        expect_out("vic_play_mp", F_MP, 0);
        tick();
        mouse_left = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
